// File: rtl/branch_predict_unit_pkg.sv
// Shared types and constants for the branch resolution unit and its BTB.
package branch_pkg;

    // Halt FSM: the core either runs or is parked at the halt vector.
    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } brstate_t;

    // One BTB entry. Tag is held zero-extended so the struct does not depend
    // on PC_W; only the low PC_W-IDX_W-2 bits are ever non-zero.
    typedef struct packed {
        logic        valid;
        logic [31:0] tag;
        logic [31:0] target;
        logic [1:0]  ctr;
    } btb_entry_t;

    // Counter values used when a branch is first allocated.
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;

    // Two-bit saturating counter step towards the observed outcome.
    function automatic logic [1:0] ctrStep(input logic [1:0] ctr, input logic taken);
        logic [1:0] next;
        next = ctr;
        if (taken && ctr != 2'b11) begin
            next = ctr + 2'b01;
        end else if (!taken && ctr != 2'b00) begin
            next = ctr - 2'b01;
        end
        return next;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Bundle of the IF lookup and EX resolution signals of the branch unit.
interface branch_predict_unit_if #(parameter int PC_W = 9);

    logic [PC_W-1:0] if_pc;
    logic            if_pred_tkn;
    logic [31:0]     if_pred_pc;

    logic            ex_valid;
    logic [PC_W-1:0] ex_pc;
    logic [31:0]     ex_imm;
    logic [31:0]     ex_rs1;
    logic            ex_branch;
    logic            ex_jal;
    logic            ex_jalr;
    logic            ex_halt;
    logic [31:0]     ex_alu_res;
    logic            ex_pred_tkn;
    logic [31:0]     ex_pred_pc;

    logic [31:0]     PC_Imm;
    logic [31:0]     PC_Four;
    logic [31:0]     BrPC;
    logic            PcSel;
    logic            flush;
    logic            halted;

    // The pipeline side drives lookups and EX operands.
    modport master (
        output if_pc, ex_valid, ex_pc, ex_imm, ex_rs1, ex_branch, ex_jal, ex_jalr,
               ex_halt, ex_alu_res, ex_pred_tkn, ex_pred_pc,
        input  if_pred_tkn, if_pred_pc, PC_Imm, PC_Four, BrPC, PcSel, flush, halted
    );

    // The branch unit consumes them and returns prediction and redirect.
    modport slave (
        input  if_pc, ex_valid, ex_pc, ex_imm, ex_rs1, ex_branch, ex_jal, ex_jalr,
               ex_halt, ex_alu_res, ex_pred_tkn, ex_pred_pc,
        output if_pred_tkn, if_pred_pc, PC_Imm, PC_Four, BrPC, PcSel, flush, halted
    );

endinterface

// File: rtl/branch_predict_unit_btb_table.sv
// Direct-mapped branch target buffer: combinational lookup, one update per clock.
module btb_table
    import branch_pkg::*;
#(
    parameter int PC_W      = 9,
    parameter int BTB_DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] lk_pc_i,
    output logic            lk_hit_o,
    output logic            lk_tkn_o,
    output logic [31:0]     lk_target_o,
    input  logic            upd_en_i,
    input  logic [PC_W-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic [31:0]     upd_target_i
);

    localparam int IDX_W = $clog2(BTB_DEPTH);

    btb_entry_t       table_q [BTB_DEPTH];
    btb_entry_t       lkEntry;
    btb_entry_t       updEntry;
    btb_entry_t       entry_d;
    logic [IDX_W-1:0] lkIdx;
    logic [IDX_W-1:0] updIdx;
    logic [31:0]      lkTag;
    logic [31:0]      updTag;
    logic             updHit;
    logic             unusedPcBits;

    assign unusedPcBits = ^{lk_pc_i[1:0], upd_pc_i[1:0]};

    assign lkIdx   = lk_pc_i[IDX_W+1:2];
    assign lkTag   = 32'(lk_pc_i[PC_W-1:IDX_W+2]);
    assign lkEntry = table_q[lkIdx];

    assign lk_hit_o    = lkEntry.valid && (lkEntry.tag == lkTag);
    assign lk_tkn_o    = lk_hit_o && lkEntry.ctr[1];
    assign lk_target_o = lkEntry.target;

    assign updIdx   = upd_pc_i[IDX_W+1:2];
    assign updTag   = 32'(upd_pc_i[PC_W-1:IDX_W+2]);
    assign updEntry = table_q[updIdx];
    assign updHit   = updEntry.valid && (updEntry.tag == updTag);

    // New contents of the indexed entry: train on a tag hit, otherwise reallocate.
    always_comb begin
        entry_d = updEntry;
        if (updHit) begin
            entry_d.ctr = ctrStep(updEntry.ctr, upd_taken_i);
        end else begin
            entry_d.valid = 1'b1;
            entry_d.tag   = updTag;
            entry_d.ctr   = upd_taken_i ? CTR_WT : CTR_WNT;
        end
        if (upd_taken_i) begin
            entry_d.target = upd_target_i;
        end
    end

    // Storage: reset invalidates everything, otherwise write the trained entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                table_q[i] <= '0;
            end
        end else if (upd_en_i) begin
            table_q[updIdx] <= entry_d;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// EX-stage branch resolution, redirect generation and sticky halt, with BTB lookup for IF.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int          PC_W      = 9,
    parameter int          BTB_DEPTH = 16,
    parameter logic [31:0] HALT_VEC  = 32'h100
) (
    input logic                  clk,
    input logic                  reset,
    branch_predict_unit_if.slave bus
);

    brstate_t    state_q;
    brstate_t    state_d;
    logic [31:0] exPc;
    logic [31:0] pcImm;
    logic [31:0] pcFour;
    logic [31:0] jalrSum;
    logic [31:0] target;
    logic [31:0] actualPc;
    logic        taken;
    logic        mispredict;
    logic        pcSel;
    logic [31:0] brPc;
    logic        btbUpd;
    logic        lkHit;
    logic        lkTkn;
    logic [31:0] lkTarget;
    logic        unusedAluBits;

    assign unusedAluBits = ^{bus.ex_alu_res[31:1], lkHit};

    // Target arithmetic is all 32 bit and wraps modulo 2^32.
    assign exPc       = 32'(bus.ex_pc);
    assign pcImm      = exPc + bus.ex_imm;
    assign pcFour     = exPc + 32'd4;
    assign jalrSum    = bus.ex_rs1 + bus.ex_imm;
    assign target     = bus.ex_jalr ? (jalrSum & ~32'h1) : pcImm;
    assign taken      = bus.ex_jal | bus.ex_jalr | (bus.ex_branch & bus.ex_alu_res[0]);
    assign actualPc   = taken ? target : pcFour;
    assign mispredict = (taken != bus.ex_pred_tkn) | (taken & (bus.ex_pred_pc != target));

    // Redirect decision: halted or halting parks at HALT_VEC, else fix wrong predictions.
    always_comb begin
        pcSel   = 1'b0;
        brPc    = 32'h0;
        btbUpd  = 1'b0;
        state_d = state_q;
        if (state_q == HALTED) begin
            pcSel = 1'b1;
            brPc  = HALT_VEC;
        end else if (bus.ex_valid) begin
            if (bus.ex_halt) begin
                pcSel   = 1'b1;
                brPc    = HALT_VEC;
                state_d = HALTED;
            end else begin
                btbUpd = bus.ex_branch | bus.ex_jal | bus.ex_jalr;
                if (mispredict) begin
                    pcSel = 1'b1;
                    brPc  = actualPc;
                end
            end
        end
    end

    // Halt state register; only reset leaves HALTED.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    btb_table #(
        .PC_W      (PC_W),
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk          (clk),
        .reset        (reset),
        .lk_pc_i      (bus.if_pc),
        .lk_hit_o     (lkHit),
        .lk_tkn_o     (lkTkn),
        .lk_target_o  (lkTarget),
        .upd_en_i     (btbUpd),
        .upd_pc_i     (bus.ex_pc),
        .upd_taken_i  (taken),
        .upd_target_i (target)
    );

    assign bus.if_pred_tkn = lkTkn;
    assign bus.if_pred_pc  = lkTkn ? lkTarget : (32'(bus.if_pc) + 32'd4);
    assign bus.PC_Imm      = pcImm;
    assign bus.PC_Four     = pcFour;
    assign bus.BrPC        = brPc;
    assign bus.PcSel       = pcSel;
    assign bus.flush       = pcSel;
    assign bus.halted      = (state_q == HALTED);

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit with a rule-level reference model.
module tb_branch_predict_unit;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    branch_predict_unit_if #(.PC_W(9)) bus ();

    branch_predict_unit #(
        .PC_W      (9),
        .BTB_DEPTH (16),
        .HALT_VEC  (32'h100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference state: BTB as plain arrays keyed by word index, plus halt flag.
    bit          mValid [16];
    int          mTag   [16];
    logic [31:0] mTgt   [16];
    int          mCtr   [16];
    bit          mHalted;
    bit          modelReady = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int modelIdx(input logic [8:0] pc);
        return (int'(pc) / 4) % 16;
    endfunction

    function automatic int modelTag(input logic [8:0] pc);
        return int'(pc) / 64;
    endfunction

    function automatic bit modelTaken();
        return bus.ex_jal || bus.ex_jalr || (bus.ex_branch && bus.ex_alu_res[0]);
    endfunction

    function automatic logic [31:0] modelTarget();
        logic [31:0] sum;
        if (bus.ex_jalr) begin
            sum = bus.ex_rs1 + bus.ex_imm;
            return {sum[31:1], 1'b0};
        end
        return {23'd0, bus.ex_pc} + bus.ex_imm;
    endfunction

    // Compute every output from the rules and the model state, then compare.
    task automatic compareAll();
        int          i;
        bit          hit;
        bit          expTkn;
        logic [31:0] expPpc;
        logic [31:0] pcImm;
        logic [31:0] pcFour;
        logic [31:0] tgt;
        bit          tk;
        bit          expSel;
        logic [31:0] expBr;
        i      = modelIdx(bus.if_pc);
        hit    = mValid[i] && (mTag[i] == modelTag(bus.if_pc));
        expTkn = hit && (mCtr[i] >= 2);
        expPpc = expTkn ? mTgt[i] : ({23'd0, bus.if_pc} + 32'd4);
        pcImm  = {23'd0, bus.ex_pc} + bus.ex_imm;
        pcFour = {23'd0, bus.ex_pc} + 32'd4;
        tgt    = modelTarget();
        tk     = modelTaken();
        expSel = 1'b0;
        expBr  = 32'h0;
        if (mHalted || (bus.ex_valid && bus.ex_halt)) begin
            expSel = 1'b1;
            expBr  = 32'h100;
        end else if (bus.ex_valid && ((tk != bus.ex_pred_tkn) || (tk && bus.ex_pred_pc != tgt))) begin
            expSel = 1'b1;
            expBr  = tk ? tgt : pcFour;
        end
        checkOutput("model if_pred_tkn", 32'(bus.if_pred_tkn), 32'(expTkn));
        checkOutput("model if_pred_pc", bus.if_pred_pc, expPpc);
        checkOutput("model PC_Imm", bus.PC_Imm, pcImm);
        checkOutput("model PC_Four", bus.PC_Four, pcFour);
        checkOutput("model PcSel", 32'(bus.PcSel), 32'(expSel));
        checkOutput("model flush", 32'(bus.flush), 32'(expSel));
        checkOutput("model BrPC", bus.BrPC, expBr);
        checkOutput("model halted", 32'(bus.halted), 32'(mHalted));
    endtask

    // Compare process: outputs are meaningful on every cycle outside reset.
    always @(negedge clk) begin
        if (modelReady && !reset) begin
            compareAll();
        end
    end

    // Model update on the active edge, mirroring what the rules say must be learned.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                mValid[i] <= 1'b0;
            end
            mHalted    <= 1'b0;
            modelReady <= 1'b1;
        end else if (modelReady && !mHalted && bus.ex_valid) begin
            if (bus.ex_halt) begin
                mHalted <= 1'b1;
            end else if (bus.ex_branch || bus.ex_jal || bus.ex_jalr) begin
                if (mValid[modelIdx(bus.ex_pc)] && mTag[modelIdx(bus.ex_pc)] == modelTag(bus.ex_pc)) begin
                    if (modelTaken()) begin
                        mCtr[modelIdx(bus.ex_pc)] <= (mCtr[modelIdx(bus.ex_pc)] == 3) ? 3 : mCtr[modelIdx(bus.ex_pc)] + 1;
                    end else begin
                        mCtr[modelIdx(bus.ex_pc)] <= (mCtr[modelIdx(bus.ex_pc)] == 0) ? 0 : mCtr[modelIdx(bus.ex_pc)] - 1;
                    end
                end else begin
                    mValid[modelIdx(bus.ex_pc)] <= 1'b1;
                    mTag[modelIdx(bus.ex_pc)]   <= modelTag(bus.ex_pc);
                    mCtr[modelIdx(bus.ex_pc)]   <= modelTaken() ? 2 : 1;
                end
                if (modelTaken()) begin
                    mTgt[modelIdx(bus.ex_pc)] <= modelTarget();
                end
            end
        end
    end

    // Drive one EX instruction (or a bubble) plus the IF lookup address.
    task automatic applyStimulus(input logic [8:0] lkPc, input logic valid, input logic br,
                                 input logic jal, input logic jalr, input logic halt,
                                 input logic [8:0] pc, input logic [31:0] imm,
                                 input logic [31:0] rs1, input logic alu,
                                 input logic pTkn, input logic [31:0] pPc);
        bus.if_pc       = lkPc;
        bus.ex_valid    = valid;
        bus.ex_branch   = br;
        bus.ex_jal      = jal;
        bus.ex_jalr     = jalr;
        bus.ex_halt     = halt;
        bus.ex_pc       = pc;
        bus.ex_imm      = imm;
        bus.ex_rs1      = rs1;
        bus.ex_alu_res  = {31'h5A5A5A5A, alu};
        bus.ex_pred_tkn = pTkn;
        bus.ex_pred_pc  = pPc;
    endtask

    task automatic idle(input logic [8:0] lkPc);
        applyStimulus(lkPc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 9'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        idle(9'h010);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Empty BTB predicts fall-through.
        @(negedge clk);
        checkOutput("reset halted", 32'(bus.halted), 32'h0);
        checkOutput("reset pred_tkn", 32'(bus.if_pred_tkn), 32'h0);
        checkOutput("reset pred_pc", bus.if_pred_pc, 32'h14);

        // First BEQ taken, predicted not taken.
        nextCycle();
        applyStimulus(9'h010, 1, 1, 0, 0, 0, 9'h010, 32'h20, 32'h0, 1, 0, 32'h0);
        @(negedge clk);
        checkOutput("beq1 PcSel", 32'(bus.PcSel), 32'h1);
        checkOutput("beq1 BrPC", bus.BrPC, 32'h30);
        checkOutput("beq1 lookup pre-update", 32'(bus.if_pred_tkn), 32'h0);

        nextCycle();
        idle(9'h010);
        @(negedge clk);
        checkOutput("beq1 learned tkn", 32'(bus.if_pred_tkn), 32'h1);
        checkOutput("beq1 learned pc", bus.if_pred_pc, 32'h30);

        // Two more taken, then not taken while predicted taken.
        for (int k = 0; k < 2; k++) begin
            nextCycle();
            applyStimulus(9'h010, 1, 1, 0, 0, 0, 9'h010, 32'h20, 32'h0, 1, 1, 32'h30);
            @(negedge clk);
            checkOutput("beq taken correct", 32'(bus.PcSel), 32'h0);
        end
        nextCycle();
        applyStimulus(9'h010, 1, 1, 0, 0, 0, 9'h010, 32'h20, 32'h0, 0, 1, 32'h30);
        @(negedge clk);
        checkOutput("beq not-taken PcSel", 32'(bus.PcSel), 32'h1);
        checkOutput("beq not-taken BrPC", bus.BrPC, 32'h14);
        nextCycle();
        idle(9'h010);
        @(negedge clk);
        checkOutput("ctr 10 still taken", 32'(bus.if_pred_tkn), 32'h1);

        // JALR target clears bit 0.
        nextCycle();
        applyStimulus(9'h020, 1, 0, 0, 1, 0, 9'h020, 32'h4, 32'h41, 0, 1, 32'h44);
        @(negedge clk);
        checkOutput("jalr good PcSel", 32'(bus.PcSel), 32'h0);
        checkOutput("jalr good BrPC", bus.BrPC, 32'h0);
        nextCycle();
        applyStimulus(9'h020, 1, 0, 0, 1, 0, 9'h020, 32'h4, 32'h41, 0, 1, 32'h48);
        @(negedge clk);
        checkOutput("jalr bad PcSel", 32'(bus.PcSel), 32'h1);
        checkOutput("jalr bad BrPC", bus.BrPC, 32'h44);

        // Wrapping JAL at 0x1FC lands in index 15 with tag 7.
        nextCycle();
        applyStimulus(9'h03C, 1, 0, 1, 0, 0, 9'h1FC, 32'hFFFFFE04, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("wrap PC_Imm", bus.PC_Imm, 32'h0);
        checkOutput("wrap PC_Four", bus.PC_Four, 32'h200);
        checkOutput("wrap BrPC", bus.BrPC, 32'h0);
        nextCycle();
        idle(9'h03C);
        @(negedge clk);
        checkOutput("alias miss tkn", 32'(bus.if_pred_tkn), 32'h0);
        checkOutput("alias miss pc", bus.if_pred_pc, 32'h40);
        nextCycle();
        idle(9'h1FC);
        @(negedge clk);
        checkOutput("wrap hit pc", bus.if_pred_pc, 32'h0);

        // Not-taken BNE at the alias reallocates index 15.
        nextCycle();
        applyStimulus(9'h1FC, 1, 1, 0, 0, 0, 9'h03C, 32'h40, 32'h0, 0, 0, 32'h0);
        @(negedge clk);
        checkOutput("bne nt PcSel", 32'(bus.PcSel), 32'h0);
        nextCycle();
        idle(9'h1FC);
        @(negedge clk);
        checkOutput("evicted pc", bus.if_pred_pc, 32'h200);

        // HALT with a taken branch flag: halt wins, then state is sticky.
        nextCycle();
        applyStimulus(9'h010, 1, 1, 0, 0, 1, 9'h008, 32'h40, 32'h0, 1, 0, 32'h0);
        @(negedge clk);
        checkOutput("halt BrPC", bus.BrPC, 32'h100);
        checkOutput("halt PcSel", 32'(bus.PcSel), 32'h1);
        checkOutput("halt not yet halted", 32'(bus.halted), 32'h0);
        nextCycle();
        applyStimulus(9'h008, 1, 1, 0, 0, 0, 9'h008, 32'h40, 32'h0, 1, 0, 32'h0);
        @(negedge clk);
        checkOutput("halted flag", 32'(bus.halted), 32'h1);
        checkOutput("halted BrPC", bus.BrPC, 32'h100);
        nextCycle();
        idle(9'h008);
        @(negedge clk);
        checkOutput("halted no btb write", 32'(bus.if_pred_tkn), 32'h0);

        // Reset out of halt clears state and BTB.
        nextCycle();
        reset = 1'b1;
        idle(9'h010);
        nextCycle();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post-reset halted", 32'(bus.halted), 32'h0);
        checkOutput("post-reset PcSel", 32'(bus.PcSel), 32'h0);
        checkOutput("post-reset pred_pc", bus.if_pred_pc, 32'h14);

        nextCycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
